// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the MIPS register file.
// Flat-vector slicing keeps port packing consistent everywhere.
package mips_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  function automatic int slice_lsb(
    input int idx,
    input int width
  );
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: register select, r0 forced to zero, optional
// write-to-read bypass.
module rf_read_port
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]             raddr,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  logic hit;

  always_comb begin
    hit   = (BYPASS != 0) && we && (waddr == raddr);
    rdata = regs[slice_lsb(int'(raddr), DATA_W) +: DATA_W];
    if (raddr == ADDR_W'(ZERO_REG)) begin
      rdata = '0;
    end else if (hit) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// Parametrised MIPS register file: one write port, NUM_RD read
// ports, optional bypass and registered read data.
module mips_reg_file
  import mips_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int BYPASS  = 1,
  parameter int REG_OUT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH*DATA_W-1:0]  regs_q;
  logic [DEPTH*DATA_W-1:0]  regs_d;
  logic [NUM_RD*DATA_W-1:0] rd_val;

  // Slot 0 is never written, so it stays at its reset value.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != ADDR_W'(ZERO_REG))) begin
      regs_d[slice_lsb(int'(waddr), DATA_W) +: DATA_W] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .regs  (regs_q),
      .raddr (raddr[slice_lsb(i, ADDR_W) +: ADDR_W]),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rd_val[slice_lsb(i, DATA_W) +: DATA_W])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    logic [NUM_RD*DATA_W-1:0] rdata_q;
    logic [NUM_RD*DATA_W-1:0] rdata_d;

    always_comb begin
      rdata_d = rd_val;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb
    assign rdata = rd_val;
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// Scoreboard bench over four register file configurations.
// Expected values queued at stimulus time, compared on output.
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra0, ra1, ra2;

  logic [95:0] rd_a;
  logic [63:0] rd_b;
  logic [31:0] rd_c;
  logic [31:0] rd_d;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  // a: 3 ports, bypass, combinational
  mips_reg_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(3),
    .BYPASS(1), .REG_OUT(0)
  ) u_a (
    .clk(clk), .reset(reset), .we(we),
    .waddr(waddr), .wdata(wdata),
    .raddr({ra2, ra1, ra0}), .rdata(rd_a)
  );

  // b: 2 ports, no bypass, combinational
  mips_reg_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2),
    .BYPASS(0), .REG_OUT(0)
  ) u_b (
    .clk(clk), .reset(reset), .we(we),
    .waddr(waddr), .wdata(wdata),
    .raddr({ra1, ra0}), .rdata(rd_b)
  );

  // c: 16x16, no bypass, registered
  mips_reg_file #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(2),
    .BYPASS(0), .REG_OUT(1)
  ) u_c (
    .clk(clk), .reset(reset), .we(we),
    .waddr(waddr[3:0]), .wdata(wdata[15:0]),
    .raddr({ra1[3:0], ra0[3:0]}), .rdata(rd_c)
  );

  // d: 1 port, bypass, registered
  mips_reg_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(1),
    .BYPASS(1), .REG_OUT(1)
  ) u_d (
    .clk(clk), .reset(reset), .we(we),
    .waddr(waddr), .wdata(wdata),
    .raddr(ra0), .rdata(rd_d)
  );

  function automatic logic [31:0] obs(int inst, int port);
    case (inst)
      0:       return rd_a[port*32 +: 32];
      1:       return rd_b[port*32 +: 32];
      2:       return {16'h0, rd_c[port*16 +: 16]};
      default: return rd_d;
    endcase
  endfunction

  task automatic push(int inst, int port, logic [31:0] v);
    exp_t x;
    x.inst = inst;
    x.port = port;
    x.exp  = v;
    sb.push_back(x);
  endtask

  task automatic push_ab(
    logic [31:0] a0, logic [31:0] a1, logic [31:0] a2,
    logic [31:0] b0, logic [31:0] b1
  );
    push(0, 0, a0);
    push(0, 1, a1);
    push(0, 2, a2);
    push(1, 0, b0);
    push(1, 1, b1);
  endtask

  task automatic push_cd(
    logic [31:0] c0, logic [31:0] c1, logic [31:0] d0
  );
    push(2, 0, c0);
    push(2, 1, c1);
    push(3, 0, d0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    push_ab(0, 0, 0, 0, 0);
    push_cd(0, 0, 0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL reset_init i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    wr(5'd5, 32'hDEADBEEF);
    ra0 = 5'd5;
    #1;
    push_ab(32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL rst_pre i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_cd(32'hBEEF, 0, 32'hDEADBEEF);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL rst_pre_reg i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    push_ab(0, 0, 0, 0, 0);
    push_cd(0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL rst_async i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    we    = 1'b1;
    waddr = 5'd5;
    wdata = 32'hCAFEF00D;
    step();
    we = 1'b0;
    #1;
    push_ab(0, 0, 0, 0, 0);
    push_cd(0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL rst_midwrite i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    reset = 1'b0;
    #1;
    push_ab(0, 0, 0, 0, 0);
    push_cd(0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL rst_release i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd0;
    wdata = 32'hFFFFFFFF;
    ra0   = 5'd0;
    ra1   = 5'd0;
    ra2   = 5'd0;
    #1;
    push_ab(0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL zero_pre i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    step();
    push_ab(0, 0, 0, 0, 0);
    push_cd(0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL zero_post i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_write_read();
    wr(5'd7, 32'h12345678);
    ra0 = 5'd7;
    ra1 = 5'd7;
    ra2 = 5'd7;
    #1;
    push_ab(32'h12345678, 32'h12345678, 32'h12345678,
            32'h12345678, 32'h12345678);
    push_cd(0, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL wr_rd_comb i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_cd(32'h5678, 32'h5678, 32'h12345678);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL wr_rd_reg i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'h1);
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'hA5A5A5A5;
    ra0   = 5'd9;
    ra1   = 5'd9;
    ra2   = 5'd0;
    #1;
    push_ab(32'hA5A5A5A5, 32'hA5A5A5A5, 0, 32'h1, 32'h1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL bypass_comb i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_cd(32'h1, 32'h1, 32'hA5A5A5A5);
    step();
    we = 1'b0;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL bypass_reg i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_ab(32'hA5A5A5A5, 32'hA5A5A5A5, 0,
            32'hA5A5A5A5, 32'hA5A5A5A5);
    push_cd(32'hA5A5, 32'hA5A5, 32'hA5A5A5A5);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL bypass_post i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
  endtask

  task automatic test_ports();
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd31, 32'h1F);
    ra0 = 5'd1;
    ra1 = 5'd2;
    ra2 = 5'd31;
    #1;
    push_ab(32'h11, 32'h22, 32'h1F, 32'h11, 32'h22);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL ports_comb i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_cd(32'h11, 32'h22, 32'h11);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL ports_reg i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    ra0 = 5'd31;
    ra1 = 5'd31;
    ra2 = 5'd31;
    #1;
    push_ab(32'h1F, 32'h1F, 32'h1F, 32'h1F, 32'h1F);
    push_cd(32'h11, 32'h22, 32'h11);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL ports_same i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_cd(32'h1F, 32'h1F, 32'h1F);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL ports_same_reg i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd3;
    wdata = 32'hAAAA0003;
    step();
    waddr = 5'd4;
    wdata = 32'hBBBB0004;
    step();
    we  = 1'b0;
    ra0 = 5'd3;
    ra1 = 5'd4;
    ra2 = 5'd4;
    #1;
    push_ab(32'hAAAA0003, 32'hBBBB0004, 32'hBBBB0004,
            32'hAAAA0003, 32'hBBBB0004);
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL b2b_comb i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
    push_cd(32'h0003, 32'h0004, 32'hAAAA0003);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.inst, e.port) !== e.exp) begin
        bad++;
        $display("FAIL b2b_reg i%0d p%0d got=%h want=%h",
                 e.inst, e.port, obs(e.inst, e.port), e.exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] ea;
    logic [31:0] ec;
    int          r4;
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h01010101);
    end
    for (int r = 0; r < 32; r++) begin
      ra0 = 5'(r);
      ra1 = 5'(r);
      ra2 = 5'(r);
      ea  = (r == 0) ? 32'h0 : 32'(r) * 32'h01010101;
      // c only sees the low nibble; writes 16..31 land last
      r4  = r % 16;
      ec  = (r4 == 0) ? 32'h0 :
            ((32'(r4) + 32'd16) * 32'h0101) & 32'hFFFF;
      #1;
      push_ab(ea, ea, ea, ea, ea);
      while (sb.size() > 0) begin
        e = sb.pop_front(); total++;
        if (obs(e.inst, e.port) !== e.exp) begin
          bad++;
          $display("FAIL sweep_comb r%0d i%0d p%0d got=%h want=%h",
                   r, e.inst, e.port, obs(e.inst, e.port), e.exp);
        end
      end
      push_cd(ec, ec, ea);
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front(); total++;
        if (obs(e.inst, e.port) !== e.exp) begin
          bad++;
          $display("FAIL sweep_reg r%0d i%0d p%0d got=%h want=%h",
                   r, e.inst, e.port, obs(e.inst, e.port), e.exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    ra0   = '0;
    ra1   = '0;
    ra2   = '0;
    test_reset();
    test_zero_reg();
    test_write_read();
    test_bypass();
    test_ports();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
